muldiv_seq: RTL and testbench

Multicycle signed multiply/divide sequencer that owns the Hi and Lo registers of the datapath. The control unit pulses `start` with an operation and two 32-bit operands. The block runs a 32-iteration shift-add (multiply) or restoring shift-subtract (divide) loop and writes the 64-bit result into Hi/Lo. Its `hi`/`lo` outputs feed the Hi and Lo inputs of the ALU-output selector, which are read by mfhi/mflo. `busy` stalls the control unit.

---
 rtl/muldiv_seq.sv | 147 ++++++++++++++
 tb/tb_muldiv_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multicycle signed multiply/divide sequencer owning the Hi/Lo registers.
// 32-step shift-add multiply or restoring divide on magnitudes, signs applied in FIX.
module muldiv_seq (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [2:0] {StIdle, StPrep, StRun, StFix, StDone} state_e;

   state_e      state_q, state_d;
   logic        op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic [63:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        div_zero_q, div_zero_d;

   // Divide step: partial remainder lives in acc[63:32], quotient shifts into acc[31:0],
   // dividend bits are fed in from the top of a_q.
   logic [32:0] rem_sh;
   logic [32:0] rem_diff;

   always_comb begin
      rem_sh   = {acc_q[63:32], a_q[31]};
      rem_diff = rem_sh - {1'b0, b_q};
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (op && (b == 32'd0)) begin
                  state_d    = StDone;
                  div_zero_d = 1'b1;
               end else begin
                  state_d = StPrep;
                  op_d    = op;
                  a_d     = a;
                  b_d     = b;
               end
            end
         end
         StPrep: begin
            a_d       = a_q[31] ? 32'd0 - a_q : a_q;
            b_d       = b_q[31] ? 32'd0 - b_q : b_q;
            neg_res_d = a_q[31] ^ b_q[31];
            neg_rem_d = a_q[31];
            acc_d     = 64'd0;
            cnt_d     = 5'd0;
            state_d   = StRun;
         end
         StRun: begin
            cnt_d = cnt_q + 5'd1;
            if (op_q) begin
               acc_d = rem_diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                                    : {rem_diff[31:0], acc_q[30:0], 1'b1};
               a_d   = {a_q[30:0], 1'b0};
            end else begin
               // MSB-first multiplier scan: acc = 2*acc + a*bit
               acc_d = {acc_q[62:0], 1'b0} + (b_q[31] ? {32'd0, a_q} : 64'd0);
               b_d   = {b_q[30:0], 1'b0};
            end
            if (cnt_q == 5'd31) state_d = StFix;
         end
         StFix: begin
            state_d = StDone;
            if (op_q) begin
               lo_d = neg_res_q ? 32'd0 - acc_q[31:0]  : acc_q[31:0];
               hi_d = neg_rem_q ? 32'd0 - acc_q[63:32] : acc_q[63:32];
            end else begin
               {hi_d, lo_d} = neg_res_q ? 64'd0 - acc_q : acc_q;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         op_q       <= 1'b0;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         acc_q      <= 64'd0;
         cnt_q      <= 5'd0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected {div_zero,hi,lo} queued at start,
// compared when done pulses; latency, busy profile and Hi/Lo hold are also checked.
module tb_muldiv_seq;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_vec = 0;
   int n_err = 0;
   logic [64:0] sb_q[$];
   logic [31:0] prev_hi = 32'd0;
   logic [31:0] prev_lo = 32'd0;

   muldiv_seq dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: {div_zero, hi, lo} from 64-bit signed arithmetic.
   function automatic logic [64:0] model(input logic op_i, input logic [31:0] a_i,
                                         input logic [31:0] b_i);
      longint sa, sb, q, r, p;
      logic [63:0] q_l, r_l, p_l;
      sa = longint'($signed(a_i));
      sb = longint'($signed(b_i));
      if (op_i && (b_i == 32'd0)) return {1'b1, prev_hi, prev_lo};
      if (op_i) begin
         q   = sa / sb;
         r   = sa % sb;
         q_l = q;
         r_l = r;
         return {1'b0, r_l[31:0], q_l[31:0]};
      end
      p   = sa * sb;
      p_l = p;
      return {1'b0, p_l};
   endfunction

   task automatic do_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        input int rp1, input int rp2);
      logic [64:0] exp_v;
      int          exp_lat;
      int          done_cyc;
      logic        busy_ok;
      logic        hold_ok;
      exp_v   = model(op_i, a_i, b_i);
      sb_q.push_back(exp_v);
      exp_lat = (op_i && (b_i == 32'd0)) ? 1 : 35;
      @(negedge clk);
      start = 1'b1;
      op    = op_i;
      a     = a_i;
      b     = b_i;
      done_cyc = 0;
      busy_ok  = 1'b1;
      hold_ok  = 1'b1;
      for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
         @(negedge clk);
         start = (cyc == rp1) || (cyc == rp2);
         if (start) begin
            // a stray divide-by-zero would complete at once if it were accepted
            op = 1'b1;
            a  = $urandom;
            b  = 32'd0;
         end
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            done_cyc = cyc;
            check_eq("result", {div_zero, hi, lo}, sb_q.pop_front());
            prev_hi = exp_v[63:32];
            prev_lo = exp_v[31:0];
         end else if ({hi, lo} != {prev_hi, prev_lo}) begin
            hold_ok = 1'b0;
         end
      end
      check_eq("latency", 65'(done_cyc), 65'(exp_lat));
      check_eq("busy_high", 65'(busy_ok), 65'd1);
      check_eq("hilo_hold", 65'(hold_ok), 65'd1);
      @(negedge clk);
      start = 1'b0;
      check_eq("busy_after", 65'(busy), 65'd0);
      check_eq("done_after", 65'(done), 65'd0);
      @(negedge clk);
      check_eq("idle_busy", 65'(busy), 65'd0);
      check_eq("idle_done", 65'(done), 65'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 1'b0;
      a       = 32'd0;
      b       = 32'd0;
      #23;
      check_eq("rst_hi", 65'(hi), 65'd0);
      check_eq("rst_lo", 65'(lo), 65'd0);
      check_eq("rst_busy", 65'(busy), 65'd0);
      check_eq("rst_done", 65'(done), 65'd0);
      check_eq("rst_dz", 65'(div_zero), 65'd0);
      @(negedge clk);
      reset_n = 1'b1;

      do_op(1'b0, 32'd7, 32'hFFFF_FFFD, -1, -1);
      do_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1, -1);
      do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
      do_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1, -1);
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);

      // 0x33333333 * 0x55555556 = 0x11111111_22222222, then divide by zero
      do_op(1'b0, 32'h3333_3333, 32'h5555_5556, -1, -1);
      check_eq("preload", {1'b0, hi, lo}, {1'b0, 32'h1111_1111, 32'h2222_2222});
      do_op(1'b1, 32'd5, 32'd0, -1, -1);

      do_op(1'b0, 32'd3, 32'd4, 10, 35);

      for (int i = 0; i < 6; i++) begin
         do_op(1'($urandom_range(0, 1)), $urandom, (i == 3) ? 32'd0 : $urandom, -1, -1);
      end

      // Reset mid-divide must clear Hi/Lo and status immediately
      do_op(1'b0, 32'd9, 32'd9, -1, -1);
      @(negedge clk);
      start = 1'b1;
      op    = 1'b1;
      a     = 32'd100;
      b     = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_eq("arst_hi", 65'(hi), 65'd0);
      check_eq("arst_lo", 65'(lo), 65'd0);
      check_eq("arst_busy", 65'(busy), 65'd0);
      check_eq("arst_done", 65'(done), 65'd0);
      prev_hi = 32'd0;
      prev_lo = 32'd0;
      @(negedge clk);
      reset_n = 1'b1;
      do_op(1'b0, 32'd2, 32'd3, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
